// File: rtl/mem_dump_reader.sv
// Generic synchronous FIFO with the head entry presented combinationally.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: a push is dropped only when full with no same-cycle pop; callers size credits so this never happens.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push_vld,
    input  logic [WIDTH-1:0]               push_dat,
    input  logic                           pop_rdy,
    output logic [WIDTH-1:0]               head_dat,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty    = (count == '0);
    assign pop_ok   = pop_rdy && !empty;
    assign push_ok  = push_vld && ((count != CW'(DEPTH)) || pop_ok);
    assign head_dat = store[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so an empty FIFO shows zeros at its head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                store[wr_ptr] <= push_dat;
                wr_ptr        <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Streams word_count words of memory starting at base_addr out over a valid/ready port.
// Latency: first word valid 2 cycles after the start edge, then one word per cycle.
// Backpressure: reads + buffered words never exceed 2; reads pause until the consumer pops.
module mem_dump_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } entry_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t          state;
    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] issued;

    // Read-return stage: tags the word that memory presents this cycle.
    logic              rd_vld;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;

    entry_t     push_ent;
    entry_t     head;
    logic [1:0] fifo_cnt;
    logic       fifo_empty;
    logic       pop;
    logic [2:0] occ;
    logic       issue;
    logic       issue_last;

    assign pop       = out_valid && out_ready;
    // Words buffered plus the one returning now, less the one leaving this cycle.
    assign occ       = 3'(fifo_cnt) + 3'(rd_vld) - 3'(pop);
    // The read enable sees a same-cycle pop, so it is decoded from state and out_ready rather than registered.
    assign issue      = (state == S_READ) && (occ < 3'd2);
    assign issue_last = (issued == (count_q - CNT_ONE));
    assign mem_re     = issue;

    assign push_ent.last = rd_last;
    assign push_ent.addr = rd_addr;
    assign push_ent.dat  = mem_rdata;

    assign out_valid = !fifo_empty;
    assign out_data  = head.dat;
    assign out_addr  = head.addr;
    assign out_last  = head.last;

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (2)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (rd_vld),
        .push_dat (push_ent),
        .pop_rdy  (pop),
        .head_dat (head),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    // Control FSM: captures the request, steps the read address, and finishes on the last handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            count_q  <= '0;
            issued   <= '0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count_q  <= word_count;
                        mem_addr <= base_addr;
                        issued   <= '0;
                        if (word_count == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (issue) begin
                        mem_addr <= mem_addr + ADDR_ONE;
                        issued   <= issued + CNT_ONE;
                        if (issue_last) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && head.last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag each issued read so the returning word is pushed with its address and last marker.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld  <= 1'b0;
            rd_addr <= '0;
            rd_last <= 1'b0;
        end else begin
            rd_vld  <= issue;
            rd_addr <= mem_addr;
            rd_last <= issue_last;
        end
    end
endmodule

// File: tb/tb_mem_dump_reader.sv
module tb_mem_dump_reader;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    logic [DATA_W-1:0] mem [4096];

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] hs_data [$];
    logic [ADDR_W-1:0] hs_addr [$];
    logic              hs_last [$];
    int                hs_cyc  [$];
    int first_re_cyc, first_re_addr, done_cyc, done_cnt, re_cnt;
    int valid_seen, stab_err, max_ahead, busy_c1, busy_at_done;

    mem_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last)
    );

    // Synchronous-read memory: data valid the cycle after the enable.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ready_pat(input int mode, input int c);
        logic [5:0] p;
        p = 6'b101001;  // cycle order 1,0,0,1,0,1
        if (mode == 0) return 1'b1;
        return p[3'((c - 1) % 6)];
    endfunction

    // One dump: inputs change #1 after each rising edge, outputs sampled at the falling edge.
    task automatic run_dump(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] cnt,
                            input int mode, input int inj_cyc, input int max_cyc);
        logic stalled;
        logic [DATA_W-1:0] pd;
        logic [ADDR_W-1:0] pa;
        logic pl;
        int ahead;
        hs_data.delete(); hs_addr.delete(); hs_last.delete(); hs_cyc.delete();
        first_re_cyc = -1; first_re_addr = -1; done_cyc = -1; done_cnt = 0; re_cnt = 0;
        valid_seen = 0; stab_err = 0; max_ahead = 0; busy_c1 = 0; busy_at_done = 1;
        stalled = 1'b0; pd = '0; pa = '0; pl = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; word_count = cnt; out_ready = ready_pat(mode, 1);
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            start     = (c == inj_cyc);
            base_addr = (c == inj_cyc) ? 12'd100 : base;
            out_ready = ready_pat(mode, c);
            @(negedge clk);
            if (c == 1) busy_c1 = busy;
            if (mem_re) begin
                re_cnt++;
                if (first_re_cyc < 0) begin
                    first_re_cyc  = c;
                    first_re_addr = int'(mem_addr);
                end
            end
            if (out_valid) valid_seen = 1;
            if (stalled && (!out_valid || out_data != pd || out_addr != pa || out_last != pl)) stab_err++;
            if (out_valid && out_ready) begin
                hs_data.push_back(out_data);
                hs_addr.push_back(out_addr);
                hs_last.push_back(out_last);
                hs_cyc.push_back(c);
            end
            ahead = re_cnt - hs_data.size();
            if (ahead > max_ahead) max_ahead = ahead;
            stalled = out_valid && !out_ready;
            pd = out_data; pa = out_addr; pl = out_last;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = c;
                    busy_at_done = busy;
                end
            end
            if (done_cyc >= 0 && c > done_cyc) break;
        end
        start = 1'b0;
    endtask

    task automatic check_seq(input string tag, input logic [ADDR_W-1:0] base, input int n);
        int bad;
        logic [ADDR_W-1:0] a;
        bad = 0;
        chk({tag, "_count"}, hs_data.size(), n);
        for (int i = 0; i < hs_data.size() && i < n; i++) begin
            a = base + ADDR_W'(i);
            if (hs_addr[i] != a || hs_data[i] != mem[a] || hs_last[i] != (i == n - 1)) bad++;
        end
        chk({tag, "_words"}, bad, 0);
    endtask

    initial begin
        int seen_done, seen_valid;
        reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hC000_0000 | i;
        mem[2048] = 32'hA0; mem[2049] = 32'hA1; mem[2050] = 32'hA2; mem[2051] = 32'hA3;
        mem[4094] = 32'hB0; mem[4095] = 32'hB1; mem[0] = 32'hB2; mem[1] = 32'hB3;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
        chk("rst_mem_re", mem_re, 0);     chk("rst_mem_addr", mem_addr, 0);
        chk("rst_valid", out_valid, 0);   chk("rst_data", out_data, 0);
        chk("rst_addr", out_addr, 0);     chk("rst_last", out_last, 0);
        @(posedge clk); #1 reset = 1'b1;

        // Basic dump with out_ready held high.
        run_dump(12'd2048, 13'd4, 0, 0, 40);
        chk("basic_first_re_cyc", first_re_cyc, 1);
        chk("basic_first_re_addr", first_re_addr, 2048);
        chk("basic_busy_c1", busy_c1, 1);
        chk("basic_first_word_cyc", hs_cyc.size() > 0 ? hs_cyc[0] : -1, 3);
        chk("basic_last_word_cyc", hs_cyc.size() > 3 ? hs_cyc[3] : -1, 6);
        chk("basic_done_cyc", done_cyc, 7);
        chk("basic_busy_at_done", busy_at_done, 0);
        chk("basic_done_pulses", done_cnt, 1);
        check_seq("basic", 12'd2048, 4);

        // Backpressure pattern.
        run_dump(12'd2048, 13'd4, 1, 0, 60);
        check_seq("bp", 12'd2048, 4);
        chk("bp_hold", stab_err, 0);
        chk("bp_ahead_le2", max_ahead <= 2, 1);
        chk("bp_reads", re_cnt, 4);
        chk("bp_done_pulses", done_cnt, 1);

        // Address wrap.
        run_dump(12'd4094, 13'd4, 0, 0, 40);
        check_seq("wrap", 12'd4094, 4);
        chk("wrap_addr2", hs_addr.size() > 2 ? hs_addr[2] : 12'hfff, 0);
        chk("wrap_data3", hs_data.size() > 3 ? hs_data[3] : 32'h0, 32'hB3);

        // Zero length.
        run_dump(12'd2048, 13'd0, 0, 0, 20);
        chk("zero_done_cyc", done_cyc, 1);
        chk("zero_done_pulses", done_cnt, 1);
        chk("zero_mem_re", re_cnt, 0);
        chk("zero_valid", valid_seen, 0);

        // Start while busy is ignored.
        run_dump(12'd2048, 13'd4, 0, 2, 40);
        check_seq("busy_start", 12'd2048, 4);
        chk("busy_start_reads", re_cnt, 4);
        chk("busy_start_done_cyc", done_cyc, 7);

        // Full 4096-word dump, wrapping through address 0.
        run_dump(12'd2048, 13'd4096, 0, 0, 4200);
        check_seq("full", 12'd2048, 4096);
        chk("full_reads", re_cnt, 4096);
        chk("full_done_cyc", done_cyc, 4099);

        // Reset mid-dump: two words accepted, one buffered.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 12'd2048; word_count = 13'd4; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("midrst_pre_valid", out_valid, 1);
        chk("midrst_pre_data", out_data, 32'hA2);
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);        chk("midrst_done", done, 0);
        chk("midrst_mem_re", mem_re, 0);    chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_valid", out_valid, 0);  chk("midrst_data", out_data, 0);
        chk("midrst_addr", out_addr, 0);    chk("midrst_last", out_last, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        seen_done = 0; seen_valid = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen_done++;
            if (out_valid) seen_valid++;
        end
        chk("midrst_no_done", seen_done, 0);
        chk("midrst_no_valid", seen_valid, 0);
        run_dump(12'd2048, 13'd4, 0, 0, 40);
        check_seq("after_rst", 12'd2048, 4);
        chk("after_rst_done_cyc", done_cyc, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Streams a contiguous range of the CPU's word-addressed unified memory out over a valid/ready word interface after a program has run. It is the read-out counterpart to image loading: the bench or a debug host fills memory, the CPU executes, and this block drains the `.data` region (word 2048 up) for checking. It sits beside the memory stage on a dedicated synchronous read port.

## Interface
- `ADDR_W`, default 12: word-address width (4096 words).
- `DATA_W`, default 32: word width.
- `clk`, in, 1: single clock, all state on rising edge.
- `reset`, in, 1: asynchronous, active-low. Low clears all state immediately.
- `start`, in, 1: sampled in IDLE only; begins a dump.
- `base_addr`, in, ADDR_W: first word address; captured with `start`.
- `word_count`, in, ADDR_W+1: number of words, 0..4096; captured with `start`.
- `busy`, out, 1: high from the cycle after accepted `start` until the last output handshake.
- `done`, out, 1: one-cycle pulse when the dump completes.
- `mem_re`, out, 1: read enable to memory.
- `mem_addr`, out, ADDR_W: read address.
- `mem_rdata`, in, DATA_W: read data, valid exactly one cycle after `mem_re`.
- `out_valid`, out, 1: output word available.
- `out_ready`, in, 1: consumer accepts when high with `out_valid`.
- `out_data`, out, DATA_W: word.
- `out_addr`, out, ADDR_W: memory address of `out_data`.
- `out_last`, out, 1: marks final word of the dump.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: `start`=1 captures `base_addr`/`word_count` and moves to READ, or to DONE if `word_count`=0. `start` in any other state is ignored.
- READ: issues reads while issued count < `word_count` and credits allow. Credit rule: buffered + in-flight ≤ 2; a pop in the same cycle frees a credit. `mem_addr` increments by 1 per issued read, wrapping 4095→0 (ADDR_W-bit modulo). After the final read is issued, go to DRAIN.
- Returned data is written with its address into a 2-entry FIFO. The FIFO head drives `out_data`/`out_addr`, and `out_valid` = FIFO not empty. Because of the credit rule the FIFO never overflows.
- `out_last` is high when the head entry is word number `word_count`-1.
- DRAIN: waits for the handshake with `out_last`=1, then goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Output stability: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_addr` and `out_last` hold unchanged.
- Reset mid-operation returns the block to IDLE. The FIFO is emptied, any in-flight read is discarded, and no `done` pulse is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_re`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0.
- Cycle numbering: `start` is sampled at edge E0.
- First `mem_re` with `mem_addr`=`base_addr` in the cycle after E0. Data returns at E2 and is captured into the FIFO, so `out_valid`=1 after E2: 2 cycles start-to-first-word.
- With `out_ready` held 1, one word is transferred per cycle and there are no bubbles.
- When `out_ready` is deasserted, at most 2 reads are outstanding or buffered, and `mem_re` stays low until a pop.
- `busy` falls and `done` rises in the cycle after the last handshake.
- `word_count`=0: `done` pulses in the cycle after E0, and `mem_re` and `out_valid` are never asserted.
- `word_count`=4096: every address is read exactly once, starting at `base_addr` and wrapping.

## Test plan
- Basic dump: preload mem[2048..2051] = 0xA0,0xA1,0xA2,0xA3; `start`, `base_addr`=2048, `word_count`=4, `out_ready`=1 → four words on consecutive cycles with `out_addr` 2048..2051, `out_last` only on 0xA3, then `done` pulse and `busy`=0 in the same cycle.
- Backpressure: same setup, toggle `out_ready` 1,0,0,1,0,1… → identical word sequence with no loss or duplication, outputs held while stalled, never more than 2 reads ahead.
- Wrap: `base_addr`=4094, `word_count`=4 → `out_addr` 4094, 4095, 0, 1 with the matching data.
- Zero length: `word_count`=0 → `done` one cycle after the `start` edge, no `mem_re`, no `out_valid`.
- Start while busy: pulse `start` with different `base_addr` during the basic dump → ignored, original 4 words only.
- Reset mid-dump: drive `reset` low after 2 words are accepted with 1 word buffered → all outputs return to reset values immediately, no `done`. A fresh dump afterwards behaves as in the basic dump.
